// File: rtl/register_file_if.sv
// Register-file access bundle: decode/writeback side drives indices and write data,
// the register file returns the two read operands.
interface register_file_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  logic [ADDR_WIDTH-1:0] in_read1_address;
  logic [ADDR_WIDTH-1:0] in_read2_address;
  logic [ADDR_WIDTH-1:0] in_write_address;
  logic [DATA_WIDTH-1:0] in_write_data;
  logic                  in_write_enable;
  logic [DATA_WIDTH-1:0] out_read1_data;
  logic [DATA_WIDTH-1:0] out_read2_data;

  modport master (
    output in_read1_address, in_read2_address, in_write_address,
    output in_write_data, in_write_enable,
    input  out_read1_data, out_read2_data
  );

  modport slave (
    input  in_read1_address, in_read2_address, in_write_address,
    input  in_write_data, in_write_enable,
    output out_read1_data, out_read2_data
  );
endinterface

// File: rtl/register_file.sv
// RISC-V integer register file: 2 combinational read ports, 1 synchronous write port, x0 == 0.
// Optional write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module register_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic           clk,
  input  logic           reset,
  register_file_if.slave bus
);
  localparam int NREG = 1 << ADDR_WIDTH;

  logic [NREG-1:0][DATA_WIDTH-1:0] regs_q, regs_d;
  logic [DATA_WIDTH-1:0]           rd1, rd2;

  // An X enable fails the if-test, so no register is touched on an unknown enable.
  always_comb begin
    regs_d    = regs_q;
    regs_d[0] = '0;
    if (bus.in_write_enable && (bus.in_write_address != '0))
      regs_d[bus.in_write_address] = bus.in_write_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) regs_q <= '0;
    else        regs_q <= regs_d;
  end

`ifdef REGFILE_BYPASS_EN
  logic byp_vld;
  assign byp_vld = bus.in_write_enable && (bus.in_write_address != '0);
`endif

  always_comb begin
    rd1 = regs_q[bus.in_read1_address];
    rd2 = regs_q[bus.in_read2_address];
`ifdef REGFILE_BYPASS_EN
    if (byp_vld && (bus.in_write_address == bus.in_read1_address)) rd1 = bus.in_write_data;
    if (byp_vld && (bus.in_write_address == bus.in_read2_address)) rd2 = bus.in_write_data;
`endif
    // x0 and reset override everything, including the forwarded value.
    if (!reset || (bus.in_read1_address == '0)) rd1 = '0;
    if (!reset || (bus.in_read2_address == '0)) rd2 = '0;
  end

  assign bus.out_read1_data = rd1;
  assign bus.out_read2_data = rd2;
endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: directed table, corner sequences, random vs array model.
module tb_register_file;
  localparam int DW = 32;
  localparam int AW = 5;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk;
  logic reset;
  register_file_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) rf_if ();

  register_file #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (rf_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [DW-1:0] mem [32];

  typedef struct {
    logic          we;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic [AW-1:0] ra1;
    logic [AW-1:0] ra2;
    logic [DW-1:0] exp1;
    logic [DW-1:0] exp2;
  } vec_t;

  vec_t tbl [6];

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] model_rd(input logic [AW-1:0] a);
    if (a == 0) return '0;
    if (BYP && rf_if.in_write_enable && rf_if.in_write_address == a) return rf_if.in_write_data;
    return mem[a];
  endfunction

  task automatic drive(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       input logic [AW-1:0] ra1, input logic [AW-1:0] ra2);
    rf_if.in_write_enable  = we;
    rf_if.in_write_address = wa;
    rf_if.in_write_data    = wd;
    rf_if.in_read1_address = ra1;
    rf_if.in_read2_address = ra2;
  endtask

  // Advance one edge, then commit the same write into the model.
  task automatic step();
    @(posedge clk);
    if (reset && rf_if.in_write_enable && rf_if.in_write_address != 0)
      mem[rf_if.in_write_address] = rf_if.in_write_data;
    #1;
  endtask

  initial begin
    tbl[0] = '{1'b1, 5'd0,  32'd10,         5'd0,  5'd1, 32'd0,          32'd0};
    tbl[1] = '{1'b1, 5'd1,  32'd20,         5'd0,  5'd1, 32'd0,          32'd20};
    tbl[2] = '{1'b1, 5'd5,  32'd30,         5'd1,  5'd5, 32'd20,         32'd30};
    tbl[3] = '{1'b0, 5'd1,  32'hDEADBEEF,   5'd1,  5'd5, 32'd20,         32'd30};
    tbl[4] = '{1'b1, 5'd31, 32'hFFFFFFFF,   5'd31, 5'd0, 32'hFFFFFFFF,   32'd0};
    tbl[5] = '{1'b1, 5'd5,  32'h12345678,   5'd5,  5'd5, 32'h12345678,   32'h12345678};

    foreach (mem[i]) mem[i] = '0;

    // Reset held with an active write pending: outputs 0, write lost.
    reset = 1'b0;
    drive(1'b1, 5'd1, 32'hA5A5A5A5, 5'd1, 5'd1);
    repeat (2) @(posedge clk);
    #1;
    check("rst_rd1", rf_if.out_read1_data, '0);
    check("rst_rd2", rf_if.out_read2_data, '0);
    @(negedge clk);
    drive(1'b0, 5'd1, 32'hA5A5A5A5, 5'd1, 5'd5);
    reset = 1'b1;
    step();
    check("post_rst_x1", rf_if.out_read1_data, '0);
    check("post_rst_x5", rf_if.out_read2_data, '0);

    // Directed table, outputs checked after the writing edge.
    for (int i = 0; i < 6; i++) begin
      drive(tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].ra1, tbl[i].ra2);
      step();
      check($sformatf("tbl%0d_rd1", i), rf_if.out_read1_data, tbl[i].exp1);
      check($sformatf("tbl%0d_rd2", i), rf_if.out_read2_data, tbl[i].exp2);
    end

    // Same-cycle read/write of x7.
    drive(1'b1, 5'd7, 32'h55, 5'd7, 5'd0);
    #1;
    check("x7_pre_edge", rf_if.out_read1_data, BYP ? 32'h55 : 32'h0);
    step();
    check("x7_post_edge", rf_if.out_read1_data, 32'h55);

    // Random traffic against the array model.
    for (int n = 0; n < 400; n++) begin
      logic [AW-1:0] wa;
      wa = AW'($urandom_range(0, 31));
      drive(1'($urandom_range(0, 1)), wa, $urandom,
            ($urandom_range(0, 3) == 0) ? wa : AW'($urandom_range(0, 31)),
            ($urandom_range(0, 3) == 0) ? wa : AW'($urandom_range(0, 31)));
      #1;
      check("rnd_rd1", rf_if.out_read1_data, model_rd(rf_if.in_read1_address));
      check("rnd_rd2", rf_if.out_read2_data, model_rd(rf_if.in_read2_address));
      step();
    end

    // Mid-cycle asynchronous reset clears the array without a clock edge.
    drive(1'b1, 5'd9, 32'hCAFEF00D, 5'd9, 5'd5);
    step();
    check("pre_async_x9", rf_if.out_read1_data, 32'hCAFEF00D);
    drive(1'b0, 5'd9, 32'h0, 5'd9, 5'd5);
    #2;
    reset = 1'b0;
    #1;
    check("async_rd1", rf_if.out_read1_data, '0);
    check("async_rd2", rf_if.out_read2_data, '0);
    foreach (mem[i]) mem[i] = '0;
    drive(1'b1, 5'd3, 32'h77, 5'd3, 5'd9);
    step();
    @(negedge clk);
    reset = 1'b1;
    drive(1'b0, 5'd3, 32'h0, 5'd3, 5'd9);
    #1;
    check("lost_write_x3", rf_if.out_read1_data, '0);
    check("cleared_x9", rf_if.out_read2_data, '0);

    // First edge after release accepts a write.
    drive(1'b1, 5'd3, 32'h77, 5'd3, 5'd0);
    step();
    drive(1'b0, 5'd3, 32'h0, 5'd3, 5'd0);
    #1;
    check("first_write_x3", rf_if.out_read1_data, 32'h77);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
